// File: rtl/trap_control_pkg.sv
// Shared definitions for the trap controller: FSM encodings, the single-step cause
// and the rule for building interrupt cause codes.
package trap_control_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_RUN    = 4'd1,
        ST_SLEEP  = 4'd2,
        ST_EXCEPT = 4'd3
    } state_e;

    localparam logic [31:0] CAUSE_SSTEP = 32'h0000_0021;

    // Interrupt causes carry a 1 in the cause MSB and the channel index in the low bits.
    function automatic logic [31:0] irq_cause(input int unsigned causeW, input logic [3:0] idx);
        logic [31:0] c;
        c            = '0;
        c[causeW-1]  = 1'b1;
        c[3:0]       = idx;
        return c;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index priority encoder over the pending-and-enabled interrupt lines.
module trap_prio_enc #(
    parameter int NCH   = 4,
    parameter int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0]   vec,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_control.sv
// Trap controller: reset stretch, exception/interrupt/sleep sequencing, retired-instruction counter.
// Single-step trapping is compiled in only when TRAP_CONTROL_SSTEP_EN is defined.
module trap_control
    import trap_control_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CAUSE_W    = 16,
    parameter int RST_CYCLES = 7
) (
    input  logic               clock,
    input  logic               reset_in,
    input  logic [NCH-1:0]     irq_pend,
    input  logic [NCH-1:0]     irq_mask,
    input  logic               irq_gie,
    input  logic               exc_valid,
    input  logic [CAUSE_W-1:0] exc_code,
    input  logic               inst_final,
    input  logic               sleep_req,
    input  logic               sstep_en,
    input  logic               trap_ack,
    output logic               core_reset,
    output logic               trap_valid,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic [3:0]         state_out,
    output logic [63:0]        inst_count
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [63:0]        count_q, count_d;

    logic               irqAny;
    logic [IDX_W-1:0]   irqIdx;
    logic               sstepHit;

    trap_prio_enc #(.NCH(NCH), .IDX_W(IDX_W)) u_prio (
        .vec (irq_pend & irq_mask),
        .any (irqAny),
        .idx (irqIdx)
    );

`ifdef TRAP_CONTROL_SSTEP_EN
    assign sstepHit = sstep_en;
`else
    assign sstepHit = sstep_en & 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            cause_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == 8'(RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (exc_valid) begin
                    state_d = ST_EXCEPT;
                    cause_d = exc_code;
                end else if (inst_final) begin
                    // The boundary instruction retires even when it triggers a trap or sleep.
                    count_d = count_q + 64'd1;
                    if (sstepHit) begin
                        state_d = ST_EXCEPT;
                        cause_d = CAUSE_W'(CAUSE_SSTEP);
                    end else if (irq_gie && irqAny) begin
                        state_d = ST_EXCEPT;
                        cause_d = CAUSE_W'(irq_cause(CAUSE_W, 4'(irqIdx)));
                    end else if (sleep_req) begin
                        state_d = ST_SLEEP;
                    end
                end
            end
            ST_SLEEP: begin
                if (irqAny) begin
                    state_d = ST_RUN;
                end
            end
            ST_EXCEPT: begin
                if (trap_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign core_reset = (state_q == ST_RESET);
    assign trap_valid = (state_q == ST_EXCEPT);
    assign trap_cause = cause_q;
    assign state_out  = state_q;
    assign inst_count = count_q;

endmodule

// File: doc/trap_control.md
TRAP_CONTROL -- requirements
Module: trap_control

Interface
REQ-001 Parameter NCH, default 4, number of interrupt channels (legal 1..16).
REQ-002 Parameter CAUSE_W, default 16, cause-code width (legal 8..32).
REQ-003 Parameter RST_CYCLES, default 7, core-reset stretch length in cycles (legal 1..255).
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_in  in  1  asynchronous, active-low reset.
REQ-006 irq_pend  in  NCH  level-sensitive interrupt pending lines.
REQ-007 irq_mask  in  NCH  per-channel enable, 1 = enabled.
REQ-008 irq_gie  in  1  global interrupt enable.
REQ-009 exc_valid  in  1  synchronous exception request from the core.
REQ-010 exc_code  in  CAUSE_W  exception cause, sampled when exc_valid=1.
REQ-011 inst_final  in  1  core is in the final state of an instruction.
REQ-012 sleep_req  in  1  current instruction is SLEEP.
REQ-013 sstep_en  in  1  single-step trap enable.
REQ-014 trap_ack  in  1  core has taken the trap.
REQ-015 core_reset  out  1  reset to the core datapath.
REQ-016 trap_valid  out  1  trap pending toward the core.
REQ-017 trap_cause  out  CAUSE_W  cause of the pending trap.
REQ-018 state_out  out  4  current FSM state, for FPGA debugging.
REQ-019 inst_count  out  64  retired-instruction counter.

Function
REQ-020 The FSM SHALL use the states RESET=0, RUN=1, SLEEP=2, EXCEPT=3; state_out SHALL equal the current state.
REQ-021 In RESET, core_reset SHALL be 1, and the FSM SHALL move to RUN after exactly RST_CYCLES cycles, counted from the first edge after reset_in is deasserted.
REQ-022 In RUN, the controller SHALL evaluate trap conditions in a fixed priority order, highest first: exc_valid; then inst_final with sstep_en; then inst_final with irq_gie and any bit of (irq_pend AND irq_mask) set; then inst_final with sleep_req.
REQ-023 The winning condition SHALL cause the following transition and trap_cause value:
 - exception: EXCEPT, trap_cause=exc_code.
 - single-step: EXCEPT, trap_cause=CAUSE_SSTEP.
 - interrupt: EXCEPT, trap_cause={1, zeros, index}, using the lowest pending enabled channel.
 - sleep: SLEEP.
REQ-024 In EXCEPT, trap_valid SHALL be 1 and trap_cause SHALL stay stable until trap_ack=1; the FSM SHALL then return to RUN, and trap_valid SHALL be 0 the next cycle.
REQ-025 In SLEEP, any set bit of (irq_pend AND irq_mask) SHALL cause a transition to RUN, regardless of irq_gie.
REQ-026 exc_valid SHALL be ignored in SLEEP, RESET and EXCEPT.
REQ-027 inst_count SHALL increment by 1 when inst_final=1 in RUN and exc_valid=0, including the instruction that causes a single-step, interrupt or sleep transition; it SHALL wrap from 2^64-1 to 0.
REQ-028 An interrupt pending without inst_final SHALL NOT trap; it waits for the instruction boundary.
REQ-029 trap_ack outside EXCEPT SHALL have no effect.

Reset
REQ-030 Asserting reset_in SHALL, at any time including mid-trap, immediately force the following values:
 - state RESET, core_reset=1;
 - trap_valid=0, trap_cause=0;
 - inst_count=0, stretch counter=0.

Configuration
REQ-031 Single-step support SHALL be compiled in only when the macro TRAP_CONTROL_SSTEP_EN is defined.
REQ-032 Without TRAP_CONTROL_SSTEP_EN, sstep_en SHALL be ignored and the single-step priority level SHALL be removed.

Structure
REQ-033 The state encodings, CAUSE_SSTEP (value 0x0021) and the interrupt cause-MSB rule SHALL reside in the shared package trap_control_pkg.
REQ-034 The lowest-index pending-channel search SHALL be the sub-module trap_prio_enc, parametrised by NCH, with outputs any and idx.

Verification
REQ-035 Reset: hold reset_in=0, release with RST_CYCLES=7 -> core_reset=1 for exactly 7 cycles, state_out=1 on the 8th.
REQ-036 Exception vs. interrupt: exc_valid=1 with exc_code=0x0005, inst_final=1, irq_pend=0x1, irq_gie=1 in the same cycle -> trap_cause=0x0005 and inst_count unchanged.
REQ-037 Interrupt priority: irq_pend=0xC, irq_mask=0xF, irq_gie=1, pulse inst_final -> trap_cause=0x8002; trap_valid stays 1 until trap_ack, then 0.
REQ-038 Sleep wake: in SLEEP with irq_gie=0, set irq_pend=0x2 and irq_mask=0x2 -> RUN next cycle, no trap taken.
REQ-039 Counter wrap: preload inst_count to 2^64-1 by forcing, then pulse inst_final -> inst_count=0.
REQ-040 Mid-trap reset: assert reset_in while in EXCEPT -> trap_valid=0 and state_out=0 with no clock edge.
